// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-facing register block: register indices,
// PPUCTRL/PPUMASK/PPUSTATUS bit positions and the PPUDATA handshake states.
package ppu_pkg;

  typedef enum logic [2:0] {
    REG_PPUCTRL   = 3'd0,
    REG_PPUMASK   = 3'd1,
    REG_PPUSTATUS = 3'd2,
    REG_OAMADDR   = 3'd3,
    REG_OAMDATA   = 3'd4,
    REG_PPUSCROLL = 3'd5,
    REG_PPUADDR   = 3'd6,
    REG_PPUDATA   = 3'd7
  } ppu_reg_t;

  localparam int CTRL_INC32     = 2;
  localparam int CTRL_NMI_EN    = 7;
  localparam int MASK_BG_EN     = 3;
  localparam int MASK_SPR_EN    = 4;
  localparam int STATUS_VBLANK  = 7;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} ppudata_state_t;

  localparam logic [5:0] PALETTE_BASE = 6'h3F;

  // Palette RAM is served directly from the palette port rather than via VRAM.
  function automatic logic is_palette(input logic [5:0] page);
    return page == PALETTE_BASE;
  endfunction

endpackage

// File: rtl/ppu_open_bus_latch.sv
// Open-bus latch holding the last value driven on the PPU data bus.
// With PPU_OPEN_BUS_DECAY_EN defined it clears after DECAY_CYCLES idle cycles.
module ppu_open_bus_latch #(
  parameter int DECAY_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] latch_o,
  output logic       decay_o
);

`ifdef PPU_OPEN_BUS_DECAY_EN
  localparam int DECAY_W = $clog2(DECAY_CYCLES + 1);

  logic [DECAY_W-1:0] cnt;

  // Counter reloads on every access and clears the latch when it runs out.
  assign decay_o = !load && (cnt == DECAY_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_o <= '0;
      cnt     <= '0;
    end else if (load) begin
      latch_o <= load_data;
      cnt     <= DECAY_W'(DECAY_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - DECAY_W'(1);
      if (cnt == DECAY_W'(1)) latch_o <= '0;
    end
  end
`else
  // Without decay the latch simply holds; the comparison keeps the parameter referenced.
  assign decay_o = (DECAY_CYCLES < 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) latch_o <= '0;
    else if (load) latch_o <= load_data;
  end
`endif

endmodule

// File: rtl/ppu_cpu_regs.sv
// CPU-facing PPU register front-end for $2000-$2007 with buffered PPUDATA and a
// handshaked VRAM port. PPU_OPEN_BUS_DECAY_EN enables open-bus decay.
module ppu_cpu_regs #(
  parameter int X_W            = 9,
  parameter int Y_W            = 9,
  parameter int VBLANK_LINE    = 241,
  parameter int PRERENDER_LINE = 261,
  parameter int DECAY_CYCLES   = 3000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  input  logic [2:0]     addr_i,
  input  logic [7:0]     data_i,
  input  logic           we_i,
  input  logic           ce_i,
  output logic [7:0]     data_o,
  output logic           nmi_o,
  output logic [7:0]     ppuctrl_o,
  output logic [7:0]     ppumask_o,
  input  logic [7:0]     oam_addr_i,
  input  logic [7:0]     oam_data_i,
  output logic [7:0]     oam_addr_o,
  output logic           oam_addr_w_o,
  output logic [7:0]     oam_data_o,
  output logic           oam_data_w_o,
  input  logic           sprite_overflow_i,
  input  logic           sprite_0_hit_i,
  input  logic [14:0]    vram_addr_i,
  input  logic [14:0]    vram_home_addr_i,
  output logic [14:0]    vram_home_addr_o,
  output logic           vram_home_addr_we_o,
  output logic           reset_vram_to_home_o,
  output logic [2:0]     fine_x_o,
  output logic           fine_x_we_o,
  output logic           inc_vram_1_o,
  output logic           inc_vram_32_o,
  output logic           vram_req_o,
  output logic           vram_we_o,
  output logic [13:0]    vram_req_addr_o,
  output logic [7:0]     vram_wdata_o,
  input  logic           vram_ack_i,
  input  logic [7:0]     vram_rdata_i,
  input  logic [5:0]     pal_data_i,
  output logic           busy_drop_o
);
  import ppu_pkg::*;

  ppu_reg_t       reg_idx;
  ppudata_state_t state, state_next;
  logic           vblank, vblank_next, suppress, suppress_next;
  logic           sprite0, overflow, toggle;
  logic [7:0]     read_buf, latch, latch_next, rd_val, ppuctrl_next;
  logic           at_vblank, at_prerender, status_rd, ppudata_hit, accept, decay;
  logic           unused_bits;

  assign reg_idx       = ppu_reg_t'(addr_i);
  assign at_vblank     = (y_i == Y_W'(VBLANK_LINE)) && (x_i == '0);
  assign at_prerender  = (y_i == Y_W'(PRERENDER_LINE)) && (x_i == '0);
  assign status_rd     = ce_i && !we_i && (reg_idx == REG_PPUSTATUS);
  assign ppudata_hit   = ce_i && (reg_idx == REG_PPUDATA);
  assign accept        = ppudata_hit && (state == IDLE);
  assign vram_req_o    = (state == REQ);
  assign inc_vram_1_o  = accept && !ppuctrl_o[CTRL_INC32];
  assign inc_vram_32_o = accept && ppuctrl_o[CTRL_INC32];
  assign unused_bits   = vram_addr_i[14];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ppudata_hit) state_next = REQ;
      REQ:     if (vram_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A status read landing on the vblank-set cycle hides vblank for the whole frame.
  always_comb begin
    vblank_next   = vblank;
    suppress_next = suppress;
    if (at_prerender) begin
      vblank_next   = 1'b0;
      suppress_next = 1'b0;
    end else if (status_rd) begin
      vblank_next = 1'b0;
      if (at_vblank) suppress_next = 1'b1;
    end else if (at_vblank && !suppress) begin
      vblank_next = 1'b1;
    end
    ppuctrl_next = (ce_i && we_i && reg_idx == REG_PPUCTRL) ? data_i : ppuctrl_o;
  end

  always_comb begin
    rd_val = latch;
    case (reg_idx)
      REG_PPUSTATUS: rd_val = {vblank, sprite0, overflow, latch[4:0]};
      REG_OAMDATA:   rd_val = oam_data_i;
      REG_PPUDATA:   if (state == IDLE)
                       rd_val = is_palette(vram_addr_i[13:8]) ? {latch[7:6], pal_data_i} : read_buf;
      default:       rd_val = latch;
    endcase
    latch_next = we_i ? data_i : rd_val;
  end

  // Scroll/address/OAM strobes are combinational in the access cycle.
  always_comb begin
    vram_home_addr_o     = vram_home_addr_i;
    vram_home_addr_we_o  = 1'b0;
    reset_vram_to_home_o = 1'b0;
    fine_x_o             = '0;
    fine_x_we_o          = 1'b0;
    oam_addr_o           = '0;
    oam_addr_w_o         = 1'b0;
    oam_data_o           = '0;
    oam_data_w_o         = 1'b0;
    if (ce_i && we_i) begin
      case (reg_idx)
        REG_PPUCTRL: begin
          vram_home_addr_o[11:10] = data_i[1:0];
          vram_home_addr_we_o     = 1'b1;
        end
        REG_OAMADDR: begin
          oam_addr_o   = data_i;
          oam_addr_w_o = 1'b1;
        end
        REG_OAMDATA: begin
          oam_data_o   = data_i;
          oam_data_w_o = 1'b1;
          oam_addr_o   = oam_addr_i + 8'd1;
          oam_addr_w_o = 1'b1;
        end
        REG_PPUSCROLL: begin
          vram_home_addr_we_o = 1'b1;
          if (!toggle) begin
            vram_home_addr_o[4:0] = data_i[7:3];
            fine_x_o              = data_i[2:0];
            fine_x_we_o           = 1'b1;
          end else begin
            vram_home_addr_o[14:12] = data_i[2:0];
            vram_home_addr_o[9:5]   = data_i[7:3];
          end
        end
        REG_PPUADDR: begin
          vram_home_addr_we_o = 1'b1;
          if (!toggle) begin
            vram_home_addr_o[14]   = 1'b0;
            vram_home_addr_o[13:8] = data_i[5:0];
          end else begin
            vram_home_addr_o[7:0] = data_i;
            reset_vram_to_home_o  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppuctrl_o       <= '0;
      ppumask_o       <= '0;
      vblank          <= 1'b0;
      suppress        <= 1'b0;
      sprite0         <= 1'b0;
      overflow        <= 1'b0;
      toggle          <= 1'b0;
      nmi_o           <= 1'b0;
      data_o          <= '0;
      read_buf        <= '0;
      vram_req_addr_o <= '0;
      vram_we_o       <= 1'b0;
      vram_wdata_o    <= '0;
      busy_drop_o     <= 1'b0;
    end else begin
      ppuctrl_o <= ppuctrl_next;
      vblank    <= vblank_next;
      suppress  <= suppress_next;
      nmi_o     <= ppuctrl_next[CTRL_NMI_EN] & vblank_next;
      if (at_prerender) begin
        sprite0  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        sprite0  <= sprite0 | sprite_0_hit_i;
        overflow <= overflow | sprite_overflow_i;
      end
      if (ce_i && we_i && reg_idx == REG_PPUMASK) ppumask_o <= data_i;
      if (status_rd) toggle <= 1'b0;
      else if (ce_i && we_i && (reg_idx == REG_PPUSCROLL || reg_idx == REG_PPUADDR))
        toggle <= !toggle;
      if (ce_i && !we_i) data_o <= rd_val;
      else if (decay)    data_o <= '0;
      if (accept) begin
        vram_req_addr_o <= vram_addr_i[13:0];
        vram_we_o       <= we_i;
        vram_wdata_o    <= data_i;
      end
      if (state == REQ && vram_ack_i && !vram_we_o) read_buf <= vram_rdata_i;
      if (ppudata_hit && state == REQ) busy_drop_o <= 1'b1;
    end
  end

  ppu_open_bus_latch #(
    .DECAY_CYCLES(DECAY_CYCLES)
  ) u_open_bus (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ce_i),
    .load_data(latch_next),
    .latch_o  (latch),
    .decay_o  (decay)
  );

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Self-checking bench for ppu_cpu_regs: a register-level model compared every cycle
// plus directed accesses with hand-computed expectations.
module tb_ppu_cpu_regs;

  localparam int DECAY = 16;
`ifdef PPU_OPEN_BUS_DECAY_EN
  localparam logic [7:0] DECAY_EXP = 8'h00;
`else
  localparam logic [7:0] DECAY_EXP = 8'h5A;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  x_i = 9'd5, y_i = 9'd10;
  logic [2:0]  addr_i = '0;
  logic [7:0]  data_i = '0;
  logic        we_i = 1'b0, ce_i = 1'b0;
  logic [7:0]  data_o, ppuctrl_o, ppumask_o;
  logic        nmi_o;
  logic [7:0]  oam_addr_i = '0, oam_data_i = '0, oam_addr_o, oam_data_o;
  logic        oam_addr_w_o, oam_data_w_o;
  logic        sprite_overflow_i = 1'b0, sprite_0_hit_i = 1'b0;
  logic [14:0] vram_addr_i = '0, vram_home_addr_i = '0, vram_home_addr_o;
  logic        vram_home_addr_we_o, reset_vram_to_home_o;
  logic [2:0]  fine_x_o;
  logic        fine_x_we_o, inc_vram_1_o, inc_vram_32_o;
  logic        vram_req_o, vram_we_o;
  logic [13:0] vram_req_addr_o;
  logic [7:0]  vram_wdata_o;
  logic        vram_ack_i = 1'b0;
  logic [7:0]  vram_rdata_i = '0;
  logic [5:0]  pal_data_i = '0;
  logic        busy_drop_o;

  int checks = 0;
  int failures = 0;
  int inc1_count = 0;
  int inc_base;
  bit compare_en = 1'b0;

  logic [14:0] snap_home;
  logic        snap_home_we, snap_reset, snap_fx_we, snap_oam_aw, snap_oam_dw, snap_inc1, snap_inc32;
  logic [2:0]  snap_fx;
  logic [7:0]  snap_oam_addr, snap_oam_data;

  always #5 clk = ~clk;

  ppu_cpu_regs #(
    .X_W(9), .Y_W(9), .VBLANK_LINE(241), .PRERENDER_LINE(261), .DECAY_CYCLES(DECAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .y_i(y_i), .addr_i(addr_i), .data_i(data_i),
    .we_i(we_i), .ce_i(ce_i), .data_o(data_o), .nmi_o(nmi_o), .ppuctrl_o(ppuctrl_o),
    .ppumask_o(ppumask_o), .oam_addr_i(oam_addr_i), .oam_data_i(oam_data_i),
    .oam_addr_o(oam_addr_o), .oam_addr_w_o(oam_addr_w_o), .oam_data_o(oam_data_o),
    .oam_data_w_o(oam_data_w_o), .sprite_overflow_i(sprite_overflow_i),
    .sprite_0_hit_i(sprite_0_hit_i), .vram_addr_i(vram_addr_i),
    .vram_home_addr_i(vram_home_addr_i), .vram_home_addr_o(vram_home_addr_o),
    .vram_home_addr_we_o(vram_home_addr_we_o), .reset_vram_to_home_o(reset_vram_to_home_o),
    .fine_x_o(fine_x_o), .fine_x_we_o(fine_x_we_o), .inc_vram_1_o(inc_vram_1_o),
    .inc_vram_32_o(inc_vram_32_o), .vram_req_o(vram_req_o), .vram_we_o(vram_we_o),
    .vram_req_addr_o(vram_req_addr_o), .vram_wdata_o(vram_wdata_o),
    .vram_ack_i(vram_ack_i), .vram_rdata_i(vram_rdata_i), .pal_data_i(pal_data_i),
    .busy_drop_o(busy_drop_o)
  );

  // What the CPU-visible register file should hold after each clock.
  typedef struct {
    logic [7:0]  ctrl, mask, latch, buffer, wdata, data;
    logic [13:0] req_addr;
    bit          vbl, s0, ovf, hidden, busy, req_we, drop, nmi;
    int          idle;
  } model_t;

  model_t m;

  function automatic model_t modelReset();
    model_t r;
    r.ctrl = '0; r.mask = '0; r.latch = '0; r.buffer = '0; r.wdata = '0; r.data = '0;
    r.req_addr = '0; r.vbl = 0; r.s0 = 0; r.ovf = 0; r.hidden = 0; r.busy = 0;
    r.req_we = 0; r.drop = 0; r.nmi = 0; r.idle = DECAY;
    return r;
  endfunction

  function automatic model_t modelNext(model_t c);
    model_t     n;
    logic [7:0] shown;
    bit         vbl_dot, pre_dot, status_read;
    n = c;
    vbl_dot     = (y_i == 9'd241) && (x_i == 9'd0);
    pre_dot     = (y_i == 9'd261) && (x_i == 9'd0);
    status_read = ce_i && !we_i && (addr_i == 3'd2);
    if (ce_i) begin
      n.idle = 0;
      if (we_i) begin
        n.latch = data_i;
        if (addr_i == 3'd0) n.ctrl = data_i;
        if (addr_i == 3'd1) n.mask = data_i;
        if (addr_i == 3'd7) begin
          if (c.busy) n.drop = 1;
          else begin
            n.busy = 1; n.req_we = 1; n.req_addr = vram_addr_i[13:0]; n.wdata = data_i;
          end
        end
      end else begin
        shown = c.latch;
        if (addr_i == 3'd2) shown = {c.vbl, c.s0, c.ovf, c.latch[4:0]};
        else if (addr_i == 3'd4) shown = oam_data_i;
        else if (addr_i == 3'd7) begin
          if (c.busy) n.drop = 1;
          else begin
            shown = (vram_addr_i[13:8] == 6'h3F) ? {c.latch[7:6], pal_data_i} : c.buffer;
            n.busy = 1; n.req_we = 0; n.req_addr = vram_addr_i[13:0]; n.wdata = data_i;
          end
        end
        n.data = shown;
        n.latch = shown;
      end
    end
`ifdef PPU_OPEN_BUS_DECAY_EN
    else if (n.idle < DECAY) begin
      n.idle = n.idle + 1;
      if (n.idle == DECAY) begin
        n.latch = '0;
        n.data = '0;
      end
    end
`endif
    if (c.busy && vram_ack_i) begin
      n.busy = 0;
      if (!c.req_we) n.buffer = vram_rdata_i;
    end
    if (pre_dot) begin
      n.vbl = 0; n.s0 = 0; n.ovf = 0; n.hidden = 0;
    end else begin
      if (sprite_0_hit_i) n.s0 = 1;
      if (sprite_overflow_i) n.ovf = 1;
      if (status_read) begin
        n.vbl = 0;
        if (vbl_dot) n.hidden = 1;
      end else if (vbl_dot && !c.hidden) n.vbl = 1;
    end
    n.nmi = n.ctrl[7] && n.vbl;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= modelReset();
    else        m <= modelNext(m);
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && compare_en) begin
      checkOutput("model data_o", 16'(data_o), 16'(m.data));
      checkOutput("model nmi_o", 16'(nmi_o), 16'(m.nmi));
      checkOutput("model ppuctrl_o", 16'(ppuctrl_o), 16'(m.ctrl));
      checkOutput("model ppumask_o", 16'(ppumask_o), 16'(m.mask));
      checkOutput("model vram_req_o", 16'(vram_req_o), 16'(m.busy));
      checkOutput("model busy_drop_o", 16'(busy_drop_o), 16'(m.drop));
      if (m.busy) begin
        checkOutput("model vram_req_addr_o", 16'(vram_req_addr_o), 16'(m.req_addr));
        checkOutput("model vram_we_o", 16'(vram_we_o), 16'(m.req_we));
        if (m.req_we) checkOutput("model vram_wdata_o", 16'(vram_wdata_o), 16'(m.wdata));
      end
    end
  end

  always @(negedge clk) begin
    if (inc_vram_1_o) inc1_count <= inc1_count + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One CPU access; combinational strobes are captured mid-cycle.
  task automatic applyStimulus(input logic [2:0] a, input logic w, input logic [7:0] d);
    addr_i = a; we_i = w; data_i = d; ce_i = 1'b1;
    @(negedge clk);
    snap_home = vram_home_addr_o;   snap_home_we = vram_home_addr_we_o;
    snap_reset = reset_vram_to_home_o;
    snap_fx = fine_x_o;             snap_fx_we = fine_x_we_o;
    snap_oam_addr = oam_addr_o;     snap_oam_aw = oam_addr_w_o;
    snap_oam_data = oam_data_o;     snap_oam_dw = oam_data_w_o;
    snap_inc1 = inc_vram_1_o;       snap_inc32 = inc_vram_32_o;
    @(posedge clk);
    #1;
    ce_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic ackVram(input logic [7:0] rd);
    vram_ack_i = 1'b1; vram_rdata_i = rd;
    tick(1);
    vram_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick(3);
    checkOutput("reset data_o", 16'(data_o), 16'h00);
    checkOutput("reset nmi_o", 16'(nmi_o), 16'h0);
    checkOutput("reset ppuctrl_o", 16'(ppuctrl_o), 16'h00);
    checkOutput("reset vram_req_o", 16'(vram_req_o), 16'h0);
    rst_n = 1'b1;
    compare_en = 1'b1;
    tick(1);

    applyStimulus(3'd2, 1'b0, 8'h00);
    checkOutput("status after reset", 16'(data_o), 16'h00);

    applyStimulus(3'd5, 1'b1, 8'h7D);
    checkOutput("scroll1 fine_x", 16'(snap_fx), 16'h5);
    checkOutput("scroll1 fine_x_we", 16'(snap_fx_we), 16'h1);
    checkOutput("scroll1 home", 16'(snap_home), 16'h000F);
    applyStimulus(3'd5, 1'b1, 8'h5E);
    checkOutput("scroll2 home", 16'(snap_home), 16'h6160);
    checkOutput("scroll2 fine_x_we", 16'(snap_fx_we), 16'h0);

    y_i = 9'd241; x_i = 9'd0; tick(1);
    x_i = 9'd1; tick(1);
    x_i = 9'd2;
    applyStimulus(3'd0, 1'b1, 8'h80);
    checkOutput("nmi after ctrl write", 16'(nmi_o), 16'h1);
    applyStimulus(3'd2, 1'b0, 8'h00);
    checkOutput("status in vblank", 16'(data_o), 16'h80);
    checkOutput("nmi after status read", 16'(nmi_o), 16'h0);

    y_i = 9'd10; x_i = 9'd5;
    sprite_0_hit_i = 1'b1; sprite_overflow_i = 1'b1; tick(1);
    sprite_0_hit_i = 1'b0; sprite_overflow_i = 1'b0;
    applyStimulus(3'd2, 1'b0, 8'h00);
    checkOutput("status s0 ovf", 16'(data_o), 16'h60);
    y_i = 9'd261; x_i = 9'd0; sprite_0_hit_i = 1'b1; tick(1);
    sprite_0_hit_i = 1'b0; y_i = 9'd10; x_i = 9'd5;
    applyStimulus(3'd2, 1'b0, 8'h00);
    checkOutput("prerender clear beats set", 16'(data_o), 16'h00);

    y_i = 9'd241; x_i = 9'd0;
    applyStimulus(3'd2, 1'b0, 8'h00);
    checkOutput("race status bit7", 16'(data_o), 16'h00);
    x_i = 9'd1; tick(20);
    checkOutput("race nmi stays low", 16'(nmi_o), 16'h0);
    applyStimulus(3'd2, 1'b0, 8'h00);
    checkOutput("race vblank hidden", 16'(data_o), 16'h00);
    y_i = 9'd261; x_i = 9'd0; tick(1);
    y_i = 9'd10; x_i = 9'd5;

    applyStimulus(3'd0, 1'b1, 8'h00);
    inc_base = inc1_count;
    vram_home_addr_i = 15'h0000;
    applyStimulus(3'd6, 1'b1, 8'h21);
    checkOutput("addr1 home", 16'(snap_home), 16'h2100);
    checkOutput("addr1 reset pulse", 16'(snap_reset), 16'h0);
    vram_home_addr_i = 15'h2100;
    applyStimulus(3'd6, 1'b1, 8'h00);
    checkOutput("addr2 home", 16'(snap_home), 16'h2100);
    checkOutput("addr2 reset pulse", 16'(snap_reset), 16'h1);
    vram_addr_i = 15'h2100;
    applyStimulus(3'd7, 1'b0, 8'h00);
    checkOutput("ppudata read1 old buffer", 16'(data_o), 16'h00);
    checkOutput("ppudata req addr", 16'(vram_req_addr_o), 16'h2100);
    ackVram(8'hAA);
    vram_addr_i = 15'h2101;
    applyStimulus(3'd7, 1'b0, 8'h00);
    checkOutput("ppudata read2", 16'(data_o), 16'h00AA);
    ackVram(8'hBB);
    checkOutput("inc_vram_1 pulses", 16'(inc1_count - inc_base), 16'd2);

    applyStimulus(3'd2, 1'b1, 8'hC0);
    vram_addr_i = 15'h3F01; pal_data_i = 6'h2C;
    applyStimulus(3'd7, 1'b0, 8'h00);
    checkOutput("palette read", 16'(data_o), 16'h00EC);
    ackVram(8'h11);

    applyStimulus(3'd0, 1'b1, 8'h04);
    vram_addr_i = 15'h2000;
    applyStimulus(3'd7, 1'b0, 8'h00);
    checkOutput("inc32 pulse", 16'({snap_inc32, snap_inc1}), 16'h2);
    ackVram(8'h22);
    applyStimulus(3'd0, 1'b1, 8'h00);

    inc_base = inc1_count;
    applyStimulus(3'd7, 1'b1, 8'h33);
    tick(5);
    checkOutput("held req", 16'(vram_req_o), 16'h1);
    applyStimulus(3'd7, 1'b1, 8'h44);
    checkOutput("busy drop flag", 16'(busy_drop_o), 16'h1);
    checkOutput("held wdata", 16'(vram_wdata_o), 16'h33);
    ackVram(8'h00);
    checkOutput("single increment", 16'(inc1_count - inc_base), 16'd1);

    oam_addr_i = 8'h10;
    applyStimulus(3'd4, 1'b1, 8'h77);
    checkOutput("oam data strobe", 16'({snap_oam_dw, snap_oam_data}), 16'h0177);
    checkOutput("oam addr incr", 16'({snap_oam_aw, snap_oam_addr}), 16'h0111);
    oam_data_i = 8'h5E;
    applyStimulus(3'd4, 1'b0, 8'h00);
    checkOutput("oam read", 16'(data_o), 16'h5E);
    checkOutput("oam read no addr write", 16'(snap_oam_aw), 16'h0);
    applyStimulus(3'd1, 1'b1, 8'h1E);
    checkOutput("ppumask", 16'(ppumask_o), 16'h1E);

    applyStimulus(3'd2, 1'b1, 8'h5A);
    tick(DECAY);
    applyStimulus(3'd0, 1'b0, 8'h00);
    checkOutput("open bus after idle", 16'(data_o), 16'(DECAY_EXP));

    applyStimulus(3'd7, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset drops req", 16'(vram_req_o), 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("post reset data_o", 16'(data_o), 16'h00);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_cpu_regs.md
# ppu_cpu_regs

Parametrised CPU-facing PPU register front-end, replacing the single-cycle register decoder. Decodes $2000–$2007 accesses, owns PPUCTRL/PPUMASK, status flags, write toggle and NMI, and adds a PPUDATA read buffer, palette-direct reads, a handshaked VRAM access port, vblank/status-read race suppression and optional open-bus decay. Sits between the CPU bus bridge and the PPU scroll/VRAM/OAM datapath.

## Interface
Parameters:
- X_W, 9, dot counter width
- Y_W, 9, scanline counter width
- VBLANK_LINE, 241, scanline on which vblank sets (at dot 0)
- PRERENDER_LINE, 261, scanline on which flags clear (at dot 0)
- DECAY_CYCLES, 3000000, open-bus decay period in clk cycles; DECAY_W = $clog2(DECAY_CYCLES+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- x_i / y_i  in  X_W / Y_W  current dot / scanline
- addr_i  in  3  register index
- data_i  in  8  CPU write data
- we_i  in  1  write (1) / read (0)
- ce_i  in  1  access strobe, one cycle per CPU access
- data_o  out  8  registered read data / open-bus latch
- nmi_o  out  1  registered ppuctrl_o[7] & vblank
- ppuctrl_o / ppumask_o  out  8 / 8  last written PPUCTRL / PPUMASK
- oam_addr_i / oam_data_i  in  8 / 8  current OAM address / data
- oam_addr_o, oam_addr_w_o  out  8, 1  OAM address write
- oam_data_o, oam_data_w_o  out  8, 1  OAM data write
- sprite_overflow_i / sprite_0_hit_i  in  1 / 1  set pulses
- vram_addr_i  in  15  current v register
- vram_home_addr_i / vram_home_addr_o  in / out  15  t register read / next value
- vram_home_addr_we_o, reset_vram_to_home_o  out  1, 1  t write; copy t→v
- fine_x_o, fine_x_we_o  out  3, 1  fine X write
- inc_vram_1_o / inc_vram_32_o  out  1 / 1  v increment pulses
- vram_req_o, vram_we_o  out  1, 1  VRAM request (held until ack), direction
- vram_req_addr_o, vram_wdata_o  out  14, 8  captured address, write data
- vram_ack_i, vram_rdata_i  in  1, 8  completion, read data (valid with ack)
- pal_data_i  in  6  palette RAM data at vram_addr_i, combinational
- busy_drop_o  out  1  sticky: PPUDATA access dropped while busy

## Operation
- Reset: all outputs and state 0; toggle 0; FSM IDLE.
- Writes: 0 PPUCTRL (t[11:10]=d[1:0]); 1 PPUMASK; 3 OAMADDR; 4 OAMDATA (data write, addr+1); 5/6 SCROLL/ADDR with write toggle (6 second write pulses reset_vram_to_home_o, first clears t[14]); every write loads open-bus latch with data_i.
- Reads: 2 returns {vblank, s0, ovf, latch[4:0]}, clears vblank and toggle; 4 returns oam_data_i, no address increment; 7 see below; write-only indices return latch. Read value also loads latch.
- PPUDATA FSM IDLE→REQ on accepted access: capture vram_addr_i[13:0] into vram_req_addr_o, pulse increment (by ppuctrl_o[2]). Read: data_o ← {latch[7:6], pal_data_i} if vram_addr_i[13:8]==6'h3F else read buffer; on ack buffer ← vram_rdata_i. REQ→IDLE on ack.
- PPUDATA access in REQ: dropped (no increment, no request), busy_drop_o set until reset.
- Flags: vblank sets at (VBLANK_LINE,0); s0/ovf OR-accumulate pulses; all three clear at (PRERENDER_LINE,0), clear beats same-cycle set pulse.
- Race: PPUSTATUS read in the vblank-set cycle returns bit7=0 and vblank stays 0 that frame (no NMI).

## Timing
- data_o, nmi_o valid the cycle after ce_i; nmi_o rises one cycle after PPUCTRL[7] written 1 during vblank.
- vram_req_o asserts the cycle after ce_i, held stable (addr/data/we) until vram_ack_i; ack in the same cycle as req completes; minimum 1-cycle REQ.
- Increment pulse and OAM/home-address strobes are combinational in the ce_i cycle.
- Reset mid-request: vram_req_o drops asynchronously; pending transfer abandoned.

## Configuration
- PPU_OPEN_BUS_DECAY_EN defined: decay counter reloads on every ce_i; after DECAY_CYCLES cycles without access latch and data_o clear to 0.
- Undefined: latch holds indefinitely; no counter synthesised.

## Structure
- ppu_pkg: register index enum (PPUCTRL..PPUDATA), PPUCTRL/PPUMASK bit constants, ppudata_state_t {IDLE, REQ}, palette base 6'h3F.
- Sub-module ppu_open_bus_latch: latch plus optional decay counter.

## Test plan
- Reset, read $2002 → data_o 8'h00; write $2000=8'h80 at (241,0)+2 → nmi_o 1 next cycle.
- Read $2002 exactly at (241,0) → bit7 0, nmi_o stays 0 all frame.
- PPUADDR 8'h21,8'h00; read $2007 twice, ack rdata 8'hAA then 8'hBB → first data_o old buffer, second 8'hAA; inc_vram_1_o pulses twice.
- v=15'h3F01, pal_data_i 6'h2C, latch 8'hC0 → $2007 read data_o 8'hEC immediately.
- $2007 write, ack withheld 5 cycles, second $2007 access → dropped, busy_drop_o 1, one increment only.
- Macro on, DECAY_CYCLES=16: write 8'h5A to $2002, idle 16 cycles → read $2000 returns 8'h00; macro off → 8'h5A.
